// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: datapath width and opcode encoding.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational core of the ALU: modulo-256 add/sub, bitwise OR/AND.
module alu_comb
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i1,
    input  logic [ALU_W-1:0] i2,
    input  logic [2:1]       opcode,
    output logic [ALU_W-1:0] res
);

    // Select the operation; carry/borrow out of the 8-bit result is dropped.
    always_comb begin
        res = '0;
        unique case (alu_op_t'(opcode))
            OP_ADD: res = i1 + i2;
            OP_SUB: res = i1 - i2;
            OP_OR:  res = i1 | i2;
            OP_AND: res = i1 & i2;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit two-operand ALU with a registered result and synchronous reset.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] i1,
    input  logic [ALU_W-1:0] i2,
    input  logic [2:1]       opcode,
    output logic [ALU_W-1:0] o1
);

    logic [ALU_W-1:0] res;

    alu_comb u_comb (
        .i1     (i1),
        .i2     (i2),
        .opcode (opcode),
        .res    (res)
    );

    // Output register: rewritten every edge, reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            o1 <= '0;
        end else begin
            o1 <= res;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps plus randomized vectors.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] i1;
    logic [7:0] i2;
    logic [2:1] opcode;
    logic [7:0] o1;

    int vectors;
    int miscompares;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .i1     (i1),
        .i2     (i2),
        .opcode (opcode),
        .o1     (o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour from the opcode table, using plain integer arithmetic.
    function automatic logic [7:0] model(input int a, input int b, input int op, input bit r);
        int v;
        if (r) return 8'd0;
        case (op)
            0:       v = (a + b) % 256;
            1:       v = (a - b + 256) % 256;
            2:       v = a | b;
            default: v = a & b;
        endcase
        return 8'(v);
    endfunction

    // Drive inputs at the falling edge, then check o1 just after the next rising edge.
    task automatic step(input int a, input int b, input int op, input bit r,
                        input logic [7:0] exp, input string tag);
        @(negedge clk);
        i1     = 8'(a);
        i2     = 8'(b);
        opcode = 2'(op);
        rst    = r;
        @(posedge clk);
        #1;
        vectors++;
        assert (o1 === exp) else begin
            miscompares++;
            $error("FAIL %s: o1=%0d expected=%0d", tag, o1, exp);
        end
    endtask

    // Change inputs between edges and confirm the registered output holds.
    task automatic hold_check(input logic [7:0] exp, input string tag);
        @(negedge clk);
        i1     = 8'($urandom);
        i2     = 8'($urandom);
        opcode = 2'($urandom);
        #2;
        vectors++;
        assert (o1 === exp) else begin
            miscompares++;
            $error("FAIL %s: o1=%0d expected=%0d", tag, o1, exp);
        end
    endtask

    initial begin
        int a, b, op;
        bit r;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        i1     = 8'd5;
        i2     = 8'd10;
        opcode = 2'b00;

        // Reset held for two edges, then first result after release
        step(5, 10, 0, 1'b1, 8'd0,  "reset_1");
        step(5, 10, 0, 1'b1, 8'd0,  "reset_2");
        step(5, 10, 0, 1'b0, 8'd15, "release_add");

        // ADD
        step(8,   10,  0, 1'b0, 8'd18, "add_8_10");
        step(8,   20,  0, 1'b0, 8'd28, "add_8_20");
        step(200, 100, 0, 1'b0, 8'd44, "add_wrap");
        hold_check(8'd44, "hold_after_add");

        // SUB
        step(100, 77, 1, 1'b0, 8'd23,  "sub_100_77");
        step(55,  77, 1, 1'b0, 8'd234, "sub_wrap");
        step(8,   2,  1, 1'b0, 8'd6,   "sub_8_2");
        step(0,   1,  1, 1'b0, 8'd255, "sub_0_1");

        // OR
        step(33, 200, 2, 1'b0, 8'd233, "or_33_200");
        step(33, 88,  2, 1'b0, 8'd121, "or_33_88");
        step(1,  28,  2, 1'b0, 8'd29,  "or_1_28");

        // AND
        step(8'hF0, 8'h3C, 3, 1'b0, 8'h30, "and_f0_3c");
        step(8'hFF, 8'hA5, 3, 1'b0, 8'hA5, "and_ff_a5");
        step(8'h00, 8'hFF, 3, 1'b0, 8'h00, "and_00_ff");
        hold_check(8'h00, "hold_after_and");

        // Back-to-back opcodes, then a single-cycle mid-stream reset
        step(10, 25, 0, 1'b0, 8'd35, "b2b_add");
        step(8,  2,  1, 1'b0, 8'd6,  "b2b_sub");
        step(1,  28, 2, 1'b0, 8'd29, "b2b_or");
        step(10, 25, 0, 1'b0, 8'd35, "b2b_add2");
        step(8,  2,  1, 1'b1, 8'd0,  "b2b_midreset");
        step(1,  28, 2, 1'b0, 8'd29, "b2b_resume_or");
        step(8,  2,  1, 1'b0, 8'd6,  "b2b_resume_sub");

        // Randomized vectors against the reference model, with sporadic resets
        for (int n = 0; n < 300; n++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 3));
            r  = ($urandom_range(0, 15) == 0);
            step(a, b, op, r, model(a, b, op, r), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

8-bit two-operand arithmetic/logic unit with a registered result. Each clock edge it takes operands `i1`, `i2` and a 2-bit opcode, and registers the result into `o1`. The supported operations are add, subtract, OR and AND. It is a leaf datapath block used wherever a small single-cycle ALU is needed.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- Parameters: none (width fixed at 8).
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `i1`  in  8  operand A, unsigned
- `i2`  in  8  operand B, unsigned
- `opcode`  in  2 (declared `[2:1]`)  operation select
- `o1`  out  8  registered result
- Connect ports by name.

## Operation
- Opcode map (bit 2 is MSB):
  - 2'b00 ADD: `i1 + i2`.
  - 2'b01 SUB: `i1 - i2`.
  - 2'b10 OR: `i1 | i2`.
  - 2'b11 AND: `i1 & i2`.
- Arithmetic is modulo 256:
  - Carry-out of ADD is discarded.
  - SUB result is two's-complement wrap (55 - 77 = 234).
  - No flags are produced.
- Operands are treated as unsigned. The result bit pattern is the same for signed interpretation.
- The next result is a pure function of the current inputs. There is no internal state other than the `o1` register.
- X/Z on `opcode` is not defined behaviour. The bench shall always drive known values.

## Timing
- `o1` updates on every rising `clk` edge from the `i1`, `i2` and `opcode` values sampled at that edge. Latency is 1 cycle and throughput is one result per cycle.
- Reset:
  - With `rst`=1 at a rising edge, `o1` becomes 8'h00. This takes priority over any operation.
  - `o1` is 8'h00 for every cycle during which `rst` is held.
  - Deassertion mid-stream: the first edge with `rst`=0 registers the result of the then-current inputs. No history is retained.
- Inputs changing between edges have no effect on `o1` until the next edge. There is no enable: `o1` is rewritten every cycle.
- Before the first reset, `o1` is undefined. The bench shall assert `rst` for at least 1 edge first.

## Structure
- Package `alu_pkg`:
  - `typedef enum logic [1:0] {OP_ADD=2'b00, OP_SUB=2'b01, OP_OR=2'b10, OP_AND=2'b11} alu_op_t;`
  - Constant `ALU_W = 8`.
- Sub-module `alu_comb`: purely combinational (`i1`, `i2`, `opcode` -> `res`), with a `unique case` on opcode.
- Top `alu`: instantiates `alu_comb` and holds a single `always_ff` output register with synchronous reset.

## Test plan
- Reset: assert `rst` for 2 cycles with `i1`=5, `i2`=10, op=00 -> `o1`=0 during reset. The first edge after release gives `o1`=15.
- ADD sequence, one result per edge with op=00 and 1-cycle latency:
  - 5+10 -> 15
  - 8+10 -> 18
  - 8+20 -> 28
  - 200+100 -> 44 (wrap)
- SUB, op=01:
  - 100-77 -> 23
  - 55-77 -> 234
  - 8-2 -> 6
  - 0-1 -> 255
- OR, op=10:
  - 33|200 -> 233
  - 33|88 -> 121
  - 1|28 -> 29
- AND, op=11:
  - 0xF0&0x3C -> 0x30
  - 0xFF&0xA5 -> 0xA5
  - 0x00&0xFF -> 0x00
- Back-to-back opcode changes with mid-stream reset: cycle opcodes 00, 01, 10 on (10,25), (8,2), (1,28) -> 35, 6, 29 on consecutive edges. Assert `rst` for one cycle in the middle -> `o1`=0 at that edge only, then the stream resumes on the next edge.
